// File: rtl/osc_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package osc_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_e;

    localparam int DEF_GATE_CYCLES   = 1000;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_CNT_W         = 16;

    // Timer width: wide enough for both the settle and gate intervals, never zero
    function automatic int timer_width(input int gate_cycles, input int settle_cycles);
        int longest;
        int width;
        longest = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a history flop and rising-edge detector.
// Brings an asynchronous level into the clk domain; rise is a one-cycle
// pulse two to three clk cycles after the input goes high. Input phases
// shorter than two clk periods may be missed.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Metastability chain (s1, s2) followed by the previous-value history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= async_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Both operands are flop outputs, so the pulse is glitch-free
    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle,
// counts synchronised rising edges over a fixed gate window and publishes
// the count with a one-cycle valid pulse and a saturation flag.
module osc_freq_meter
    import osc_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int TIMER_W = timer_width(GATE_CYCLES, SETTLE_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    meter_state_e       state_r;
    meter_state_e       state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [CNT_W-1:0]   edge_cnt_r;
    logic [CNT_W-1:0]   edge_cnt_s;
    logic               ovf_r;
    logic               ovf_s;
    logic               rise_s;

    logic               osc_en_r;
    logic               busy_r;
    logic [CNT_W-1:0]   count_r;
    logic               count_valid_r;
    logic               overflow_r;

    edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (osc_in),
        .rise     (rise_s)
    );

    // Next-state, timer and saturating edge-counter logic
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        edge_cnt_s = edge_cnt_r;
        ovf_s      = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = SETTLE;
                    timer_s    = TIMER_ZERO;
                    edge_cnt_s = CNT_ZERO;
                    ovf_s      = 1'b0;
                end else begin
                    state_s    = IDLE;
                end
            end
            SETTLE: begin
                // Oscillator start-up edges are deliberately ignored here
                if (timer_r == SETTLE_LAST) begin
                    state_s = MEASURE;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            MEASURE: begin
                // Saturate rather than wrap so a too-fast oscillator is flagged
                if (rise_s) begin
                    if (edge_cnt_r == CNT_MAX) begin
                        ovf_s = 1'b1;
                    end else begin
                        edge_cnt_s = edge_cnt_r + CNT_ONE;
                    end
                end else begin
                    edge_cnt_s = edge_cnt_r;
                end
                if (timer_r == GATE_LAST) begin
                    state_s = DONE;
                    timer_s = TIMER_ZERO;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                timer_s    = TIMER_ZERO;
                edge_cnt_s = CNT_ZERO;
                ovf_s      = 1'b0;
            end
        endcase
    end

    // FSM state, gate timer, edge counter and saturation flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            timer_r    <= TIMER_ZERO;
            edge_cnt_r <= CNT_ZERO;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            edge_cnt_r <= edge_cnt_s;
            ovf_r      <= ovf_s;
        end
    end

    // Status outputs registered from the next state so they align with state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_en_r      <= 1'b0;
            busy_r        <= 1'b0;
            count_valid_r <= 1'b0;
        end else begin
            osc_en_r      <= (state_s == SETTLE) || (state_s == MEASURE);
            busy_r        <= (state_s != IDLE);
            count_valid_r <= (state_s == DONE);
        end
    end

    // Result capture on entry to DONE; edge_cnt_s already includes a rise in
    // the final gate cycle, so count is stable for the whole valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else if (state_s == DONE) begin
            count_r    <= edge_cnt_s;
            overflow_r <= ovf_s;
        end else begin
            count_r    <= count_r;
            overflow_r <= overflow_r;
        end
    end

    assign osc_en      = osc_en_r;
    assign busy        = busy_r;
    assign count       = count_r;
    assign count_valid = count_valid_r;
    assign overflow    = overflow_r;

endmodule
